// File: rtl/stump_control_seq_pkg.sv
// Shared definitions for the Stump control sequencer: states, opcodes,
// condition codes and flag bit positions.
package stump_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_HALT    = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADC  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SBC  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_LDST = 3'd6;
    localparam logic [2:0] OP_BCC  = 3'd7;

    localparam logic [3:0] CC_AL = 4'h0;
    localparam logic [3:0] CC_NV = 4'h1;
    localparam logic [3:0] CC_HI = 4'h2;
    localparam logic [3:0] CC_LS = 4'h3;
    localparam logic [3:0] CC_CC = 4'h4;
    localparam logic [3:0] CC_CS = 4'h5;
    localparam logic [3:0] CC_NE = 4'h6;
    localparam logic [3:0] CC_EQ = 4'h7;
    localparam logic [3:0] CC_VC = 4'h8;
    localparam logic [3:0] CC_VS = 4'h9;
    localparam logic [3:0] CC_PL = 4'hA;
    localparam logic [3:0] CC_MI = 4'hB;
    localparam logic [3:0] CC_GE = 4'hC;
    localparam logic [3:0] CC_LT = 4'hD;
    localparam logic [3:0] CC_GT = 4'hE;
    localparam logic [3:0] CC_LE = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/stump_control_seq_if.sv
// ALU func/flags and memory handshake bundle between the sequencer (master)
// and the datapath/memory side (slave).
interface stump_ctrl_if;
    logic [3:0] alu_flags;
    logic       mem_wait;
    logic [2:0] alu_func;
    logic       alu_c_in;
    logic       mem_ren;
    logic       mem_wen;

    modport master (
        input  alu_flags, mem_wait,
        output alu_func, alu_c_in, mem_ren, mem_wen
    );

    modport slave (
        output alu_flags, mem_wait,
        input  alu_func, alu_c_in, mem_ren, mem_wen
    );
endinterface

// File: rtl/stump_control_seq_cond_eval.sv
// Bcc condition evaluation: 4-bit condition against {N,Z,V,C}.
module stump_cond_eval
    import stump_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);
    logic n, z, v, c;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_AL: taken = 1'b1;
            CC_NV: taken = 1'b0;
            CC_HI: taken = ~(c | z);
            CC_LS: taken = c | z;
            CC_CC: taken = ~c;
            CC_CS: taken = c;
            CC_NE: taken = ~z;
            CC_EQ: taken = z;
            CC_VC: taken = ~v;
            CC_VS: taken = v;
            CC_PL: taken = ~n;
            CC_MI: taken = n;
            CC_GE: taken = ~(n ^ v);
            CC_LT: taken = n ^ v;
            CC_GT: taken = ~((n ^ v) | z);
            CC_LE: taken = (n ^ v) | z;
        endcase
    end
endmodule

// File: rtl/stump_control_seq.sv
// Stump multi-cycle control sequencer: decode, FETCH/EXECUTE/MEMORY FSM and
// condition-code register. Define STUMP_HALT_EN to make branch-to-self halt.
module stump_control_seq
    import stump_ctrl_pkg::*;
#(
    parameter logic [2:0] PC_REG      = 3'd7,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   ir,
    stump_ctrl_if.master  bus,
    output logic [1:0]    state,
    output logic          fetch,
    output logic          reg_write,
    output logic [2:0]    dest,
    output logic [2:0]    srcA,
    output logic [2:0]    srcB,
    output logic [1:0]    shift_op,
    output logic          ext_op,
    output logic          cc_en,
    output logic [3:0]    flags_q,
    output logic          halted
);
    state_t     state_q;
    logic [2:0] op;
    logic       taken;
    logic       halt_br;

    assign op    = ir[15:13];
    assign state = state_q;

    stump_cond_eval u_cond (
        .cond  (ir[11:8]),
        .flags (flags_q),
        .taken (taken)
    );

`ifdef STUMP_HALT_EN
    assign halt_br = (op == OP_BCC) && (ir[11:8] == CC_AL) && (ir[7:0] == 8'hFF);
    assign halted  = (state_q == ST_HALT);
`else
    assign halt_br = 1'b0;
    assign halted  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            flags_q <= RESET_FLAGS;
        end else begin
            unique case (state_q)
                ST_FETCH:
                    if (!bus.mem_wait) state_q <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (cc_en) flags_q <= bus.alu_flags;
                    if (op == OP_LDST)  state_q <= ST_MEMORY;
                    else if (halt_br)   state_q <= ST_HALT;
                    else                state_q <= ST_FETCH;
                end
                ST_MEMORY:
                    if (!bus.mem_wait) state_q <= ST_FETCH;
                ST_HALT: begin
`ifdef STUMP_HALT_EN
                    state_q <= ST_HALT;
`else
                    state_q <= ST_FETCH;
`endif
                end
            endcase
        end
    end

    always_comb begin
        fetch        = 1'b0;
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b0;
        reg_write    = 1'b0;
        dest         = '0;
        srcA         = '0;
        srcB         = '0;
        shift_op     = '0;
        ext_op       = 1'b0;
        bus.alu_func = OP_ADD;
        bus.alu_c_in = 1'b0;
        cc_en        = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                fetch       = 1'b1;
                bus.mem_ren = 1'b1;
            end
            ST_EXECUTE: begin
                unique case (op)
                    OP_BCC: begin
                        srcA      = PC_REG;
                        dest      = PC_REG;
                        ext_op    = 1'b1;
                        reg_write = taken & ~halt_br;
                    end
                    OP_LDST: begin
                        // Address path only; ir[11] is the store bit here.
                        dest     = ir[10:8];
                        srcA     = ir[7:5];
                        srcB     = ir[4:2];
                        ext_op   = ir[12];
                        shift_op = ir[12] ? 2'b00 : ir[1:0];
                    end
                    default: begin
                        bus.alu_func = op;
                        dest         = ir[10:8];
                        srcA         = ir[7:5];
                        srcB         = ir[4:2];
                        ext_op       = ir[12];
                        shift_op     = ir[12] ? 2'b00 : ir[1:0];
                        reg_write    = 1'b1;
                        cc_en        = ir[11];
                    end
                endcase
                unique case (op)
                    OP_ADC, OP_SBC: bus.alu_c_in = flags_q[FLAG_C];
                    OP_SUB:         bus.alu_c_in = 1'b1;
                    default:        bus.alu_c_in = 1'b0;
                endcase
            end
            ST_MEMORY: begin
                if (ir[11]) begin
                    bus.mem_wen = 1'b1;
                    srcA        = ir[10:8];
                end else begin
                    bus.mem_ren = 1'b1;
                    reg_write   = ~bus.mem_wait;
                    dest        = ir[10:8];
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_stump_control_seq.sv
// Randomized self-checking bench for stump_control_seq against an
// instruction-level reference model.
module tb_stump_control_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [1:0]  state;
    logic        fetch, reg_write, ext_op, cc_en, halted;
    logic [2:0]  dest, srcA, srcB;
    logic [1:0]  shift_op;
    logic [3:0]  flags_q;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [3:0]  model_flags;

    stump_ctrl_if bus ();

    stump_control_seq #(.PC_REG(3'd7), .RESET_FLAGS(4'b0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .bus       (bus.master),
        .state     (state),
        .fetch     (fetch),
        .reg_write (reg_write),
        .dest      (dest),
        .srcA      (srcA),
        .srcB      (srcB),
        .shift_op  (shift_op),
        .ext_op    (ext_op),
        .cc_en     (cc_en),
        .flags_q   (flags_q),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (ir=%h t=%0t)", tag, got, exp, ir, $time);
        end
    endtask

    // Even codes test a predicate, the following odd code is its complement.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy, base;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c[3:1])
            3'd0: base = 1'b1;
            3'd1: base = !(cy || z);
            3'd2: base = !cy;
            3'd3: base = !z;
            3'd4: base = !v;
            3'd5: base = !n;
            3'd6: base = !(n ^ v);
            default: base = !((n ^ v) || z);
        endcase
        return base ^ c[0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_strobes(input string tag);
        check_val({tag, ".fetch"},   fetch, 0);
        check_val({tag, ".ren"},     bus.mem_ren, 0);
        check_val({tag, ".wen"},     bus.mem_wen, 0);
        check_val({tag, ".rw"},      reg_write, 0);
        check_val({tag, ".cc_en"},   cc_en, 0);
    endtask

    task automatic fetch_cycle(input logic w);
        bus.mem_wait  = w;
        bus.alu_flags = 4'($urandom);
        #1;
        check_val("F.state", state, 2'b00);
        check_val("F.fetch", fetch, 1);
        check_val("F.ren",   bus.mem_ren, 1);
        check_val("F.wen",   bus.mem_wen, 0);
        check_val("F.rw",    reg_write, 0);
        check_val("F.cc_en", cc_en, 0);
        check_val("F.halted", halted, 0);
        check_val("F.flags", flags_q, model_flags);
        next_cycle();
    endtask

    task automatic memory_cycle(input logic w);
        logic st;
        st = ir[11];
        bus.mem_wait = w;
        #1;
        check_val("M.state", state, 2'b10);
        check_val("M.fetch", fetch, 0);
        check_val("M.cc_en", cc_en, 0);
        check_val("M.flags", flags_q, model_flags);
        if (st) begin
            check_val("ST.wen",  bus.mem_wen, 1);
            check_val("ST.ren",  bus.mem_ren, 0);
            check_val("ST.rw",   reg_write, 0);
            check_val("ST.srcA", srcA, ir[10:8]);
        end else begin
            check_val("LD.ren",  bus.mem_ren, 1);
            check_val("LD.wen",  bus.mem_wen, 0);
            check_val("LD.rw",   reg_write, !w);
            check_val("LD.dest", dest, ir[10:8]);
        end
        next_cycle();
    endtask

    task automatic do_instr(input logic [15:0] instr, input int fw, input int mw, input logic [3:0] af);
        logic [2:0] op;
        logic       is_halt;
        ir = instr;
        op = instr[15:13];
        is_halt = 1'b0;
`ifdef STUMP_HALT_EN
        is_halt = (instr == 16'hE0FF);
`endif
        for (int i = 0; i < fw; i++) fetch_cycle(1'b1);
        fetch_cycle(1'b0);

        bus.alu_flags = af;
        bus.mem_wait  = 1'($urandom);
        #1;
        check_val("E.state", state, 2'b01);
        check_val("E.fetch", fetch, 0);
        check_val("E.ren",   bus.mem_ren, 0);
        check_val("E.wen",   bus.mem_wen, 0);
        check_val("E.flags", flags_q, model_flags);
        if (op <= 3'd5) begin
            check_val("ALU.func",  bus.alu_func, op);
            check_val("ALU.ext",   ext_op, instr[12]);
            check_val("ALU.rw",    reg_write, 1);
            check_val("ALU.dest",  dest, instr[10:8]);
            check_val("ALU.srcA",  srcA, instr[7:5]);
            check_val("ALU.srcB",  srcB, instr[4:2]);
            check_val("ALU.shift", shift_op, instr[12] ? 2'b00 : instr[1:0]);
            check_val("ALU.cc_en", cc_en, instr[11]);
            check_val("ALU.c_in",  bus.alu_c_in,
                      (op == 3'd1 || op == 3'd3) ? model_flags[0] : (op == 3'd2));
        end else if (op == 3'd6) begin
            check_val("LS.func",  bus.alu_func, 3'd0);
            check_val("LS.rw",    reg_write, 0);
            check_val("LS.cc_en", cc_en, 0);
            check_val("LS.c_in",  bus.alu_c_in, 0);
        end else begin
            check_val("B.func",  bus.alu_func, 3'd0);
            check_val("B.srcA",  srcA, 3'd7);
            check_val("B.dest",  dest, 3'd7);
            check_val("B.ext",   ext_op, 1);
            check_val("B.cc_en", cc_en, 0);
            check_val("B.c_in",  bus.alu_c_in, 0);
            check_val("B.rw",    reg_write, is_halt ? 1'b0 : cond_model(instr[11:8], model_flags));
        end
        if (op <= 3'd5 && instr[11]) model_flags = af;
        next_cycle();

        if (is_halt) begin
            for (int i = 0; i < 10; i++) begin
                bus.mem_wait = 1'($urandom);
                #1;
                check_val("H.state",  state, 2'b11);
                check_val("H.halted", halted, 1);
                check_idle_strobes("H");
                next_cycle();
            end
            rst = 1'b1;
            next_cycle();
            rst = 1'b0;
            model_flags = 4'b0000;
            check_val("H.rst_state", state, 2'b00);
            check_val("H.rst_halted", halted, 0);
        end else if (op == 3'd6) begin
            for (int i = 0; i < mw; i++) memory_cycle(1'b1);
            memory_cycle(1'b0);
        end
    endtask

    initial begin
        logic [15:0] r;
        rst = 1'b1;
        ir = '0;
        bus.mem_wait = 1'b0;
        bus.alu_flags = '0;
        model_flags = 4'b0000;
        @(posedge clk); #1;
        next_cycle();
        check_val("RST.state", state, 2'b00);
        check_val("RST.flags", flags_q, 4'b0000);
        check_val("RST.halted", halted, 0);
        rst = 1'b0;

        // ADD r2,r1,r0 with cc
        do_instr(16'h0A20, 1, 0, 4'b0100);
        // BEQ taken / not taken, BGT with N=1,V=0
        do_instr(16'hE705, 0, 0, 4'b0000);
        do_instr(16'h0800, 0, 0, 4'b0000);
        do_instr(16'hE705, 0, 0, 4'b0000);
        do_instr(16'h0800, 0, 0, 4'b1000);
        do_instr(16'hEE05, 0, 0, 4'b0000);
        // Load with 3-cycle stall
        do_instr(16'hC321, 2, 3, 4'b1111);
        // SBC with C=1, then store leaves flags alone
        do_instr(16'h0800, 0, 0, 4'b0001);
        do_instr(16'h6000, 0, 0, 4'b1110);
        do_instr(16'hCA44, 0, 2, 4'b0110);
        // Branch-to-self
        do_instr(16'hE0FF, 0, 0, 4'b0000);

        // Reset in the middle of a stalled store
        do_instr(16'h0800, 0, 0, 4'b1111);
        ir = 16'hC900;
        fetch_cycle(1'b0);
        bus.mem_wait = 1'b0;
        next_cycle();
        bus.mem_wait = 1'b1;
        #1;
        check_val("RM.wen_pre", bus.mem_wen, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        model_flags = 4'b0000;
        check_val("RM.state", state, 2'b00);
        check_val("RM.flags", flags_q, 4'b0000);
        check_val("RM.wen",   bus.mem_wen, 0);

        for (int k = 0; k < 400; k++) begin
            r = 16'($urandom);
            if (r == 16'hE0FF) r = 16'hE0FE;
            do_instr(r, $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stump_control_seq.md
Name: stump_control_seq

Overview:
- Multi-cycle control sequencer for the Stump core: the consumer side of the ALU's func/flags interface.
- Decodes the latched instruction and drives the ALU function code and carry input.
- Owns the {N,Z,V,C} condition-code register, loading it from the ALU flags output, and evaluates Bcc conditions from it.
- Sequences FETCH -> EXECUTE -> (MEMORY) with a memory wait handshake.

Parameters:
- PC_REG, 3'd7, register index used as program counter.
- RESET_FLAGS, 4'b0000, condition-code value after reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ir  in  16  current instruction from the instruction register
- alu_flags  in  4  ALU flags {N,Z,V,C}, combinational for the current EXECUTE operation
- mem_wait  in  1  memory not ready; stalls FETCH and MEMORY
- state  out  2  00 FETCH, 01 EXECUTE, 10 MEMORY, 11 HALT
- fetch  out  1  instruction fetch strobe (IR load, PC increment)
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- reg_write  out  1  register file write enable
- dest  out  3  destination register index
- srcA  out  3  operand A register index
- srcB  out  3  operand B register index
- shift_op  out  2  shifter operation
- ext_op  out  1  1 = operand B from sign-extended immediate
- alu_func  out  3  ALU function code
- alu_c_in  out  1  carry into the ALU
- cc_en  out  1  flags load enable this cycle
- flags_q  out  4  registered {N,Z,V,C}
- halted  out  1  core halted

Behaviour:
- Registered state: state, flags_q. All other outputs are combinational from state, ir and flags_q.
- Reset: on a rising edge with rst=1, state<=FETCH and flags_q<=RESET_FLAGS. rst overrides mem_wait and any in-progress MEMORY or HALT state.
- Instruction fields: ir[15:13] op, ir[12] type (immediate), ir[11] cc or store bit, ir[10:8] dest, ir[7:5] srcA, ir[4:2] srcB, ir[1:0] shift. Bcc uses ir[11:8] cond.
- FETCH: fetch=1, mem_ren=1; all other strobes 0. mem_wait=1 holds FETCH; mem_wait=0 goes to EXECUTE.
- EXECUTE, op 000-101 (ADD/ADC/SUB/SBC/AND/OR):
  - alu_func=op, ext_op=ir[12], reg_write=1, dest=ir[10:8], srcA=ir[7:5], srcB=ir[4:2].
  - shift_op=ir[1:0] when ir[12]=0, else 00.
  - cc_en=ir[11]. Next state FETCH.
- EXECUTE, op 110 (LD/ST):
  - alu_func=ADD (address = srcA + operand B), reg_write=0, cc_en=0. ir[11] is the store bit, never a cc bit.
  - Next state MEMORY.
- EXECUTE, op 111 (Bcc):
  - alu_func=ADD, srcA=PC_REG, ext_op=1 (8-bit offset), dest=PC_REG.
  - reg_write=cond_true(ir[11:8], flags_q), cc_en=0. Next state FETCH.
- alu_c_in = flags_q[0] for ADC/SBC, 0 for ADD, 1 for SUB, 0 otherwise.
- Flag load: flags_q<=alu_flags on the edge ending EXECUTE when cc_en=1; otherwise flags_q holds.
- Condition codes, evaluated from flags_q as it stands before the branch:
  - 0 AL = 1; 1 NV = 0
  - 2 HI = ~(C|Z); 3 LS = C|Z
  - 4 CC = ~C; 5 CS = C
  - 6 NE = ~Z; 7 EQ = Z
  - 8 VC = ~V; 9 VS = V
  - A PL = ~N; B MI = N
  - C GE = ~(N^V); D LT = N^V
  - E GT = ~((N^V)|Z); F LE = (N^V)|Z
- MEMORY:
  - Load (ir[11]=0): mem_ren=1; reg_write=~mem_wait; dest=ir[10:8].
  - Store (ir[11]=1): mem_wen=1; srcA=ir[10:8] supplies the store data.
  - mem_wait=1 holds MEMORY with strobes asserted; mem_wait=0 goes to FETCH.
- Encoding 11 outside HALT mode: go to FETCH, no strobes.

Optional Feature:
- Macro STUMP_HALT_EN.
- Defined: a Bcc with cond=0000 and ir[7:0]=8'hFF (branch-to-self) in EXECUTE goes to HALT instead of FETCH.
  - reg_write=0 on that cycle.
  - In HALT, all strobes are 0 and halted=1. Only rst exits HALT.
- Undefined: that branch executes normally as an infinite loop. HALT is unreachable and halted is tied 0. The port exists in both builds.

Decomposition:
- Shared package stump_ctrl_pkg: state encodings, opcode constants (ADD..BCC), the 16 condition-code constants, and flag bit indices N=3, Z=2, V=1, C=0.
- One sub-module, stump_cond_eval: combinational cond[3:0] plus flags[3:0] -> taken.
- Decode, FSM and flags register stay in stump_control_seq.

Test Plan:
- Reset: rst high mid-MEMORY with mem_wait=1 -> next edge state=FETCH, flags_q=0000, mem_wen=0.
- ADD with cc: ir=16'h0A20 (ADD r2,r1,r0, cc=1), alu_flags=0100 in EXECUTE -> alu_func=000, reg_write=1, dest=2, cc_en=1, flags_q=0100 after the edge; FETCH next.
- Branch: BEQ with flags_q Z=1 -> reg_write=1, dest=7, ext_op=1. Same instruction with Z=0 -> reg_write=0. BGT with N=1,V=0 -> not taken.
- Load with stall: LD, mem_wait=1 for 3 cycles in MEMORY -> state holds, mem_ren=1, reg_write=0. mem_wait drops -> reg_write=1 for one cycle, then FETCH.
- SBC carry: flags_q C=1, SBC in EXECUTE -> alu_c_in=1, alu_func=011. ST instruction -> cc_en=0, flags_q unchanged.
- STUMP_HALT_EN: ir=16'hE0FF in EXECUTE -> state=11, halted=1, strobes 0 for 10 cycles; rst returns to FETCH.
